// File: rtl/sprite_plotter.sv
// Sprite plotter: erases the old sprite, then draws the new one,
// one clipped pixel per clock into the VGA frame buffer.
module sprite_plotter #(
  parameter int         SPRITE_W      = 8,
  parameter int         SPRITE_H      = 8,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] SPRITE_COLOUR = 3'b110,
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       erase_en,
  input  logic [7:0] old_x,
  input  logic [6:0] old_y,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot
);

  if (SPRITE_COLOUR == 3'b010) begin : g_bad_colour
    $error("SPRITE_COLOUR 3'b010 is reserved for obstacles");
  end

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    DONE
  } state_t;

  localparam logic [3:0] DX_LAST = 4'(SPRITE_W - 1);
  localparam logic [3:0] DY_LAST = 4'(SPRITE_H - 1);
  localparam logic [8:0] X_LIM   = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM   = 8'(SCREEN_H);

  state_t     state, state_nxt;
  logic [3:0] dx, dy, dx_nxt, dy_nxt;
  logic [7:0] ox, nx, ox_nxt, nx_nxt;
  logic [6:0] oy, ny, oy_nxt, ny_nxt;

  logic       busy_nxt;
  logic       erasing;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sx;
  logic [7:0] sy;
  logic       on_screen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dx    <= '0;
      dy    <= '0;
      ox    <= '0;
      oy    <= '0;
      nx    <= '0;
      ny    <= '0;
    end else begin
      state <= state_nxt;
      dx    <= dx_nxt;
      dy    <= dy_nxt;
      ox    <= ox_nxt;
      oy    <= oy_nxt;
      nx    <= nx_nxt;
      ny    <= ny_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dx_nxt    = dx;
    dy_nxt    = dy;
    ox_nxt    = ox;
    oy_nxt    = oy;
    nx_nxt    = nx;
    ny_nxt    = ny;
    unique case (state)
      IDLE: begin
        if (start) begin
          ox_nxt    = old_x;
          oy_nxt    = old_y;
          nx_nxt    = new_x;
          ny_nxt    = new_y;
          dx_nxt    = '0;
          dy_nxt    = '0;
          state_nxt = erase_en ? ERASE : DRAW;
        end
      end
      ERASE, DRAW: begin
        if (dx == DX_LAST) begin
          dx_nxt = '0;
          if (dy == DY_LAST) begin
            dy_nxt    = '0;
            state_nxt = (state == ERASE) ? DRAW : DONE;
          end else begin
            dy_nxt = dy + 4'd1;
          end
        end else begin
          dx_nxt = dx + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next pixel so they line up with state.
  always_comb begin
    busy_nxt  = (state_nxt == ERASE) || (state_nxt == DRAW);
    erasing   = (state_nxt == ERASE);
    base_x    = erasing ? ox_nxt : nx_nxt;
    base_y    = erasing ? oy_nxt : ny_nxt;
    sx        = {1'b0, base_x} + {5'b0, dx_nxt};
    sy        = {1'b0, base_y} + {4'b0, dy_nxt};
    on_screen = (sx < X_LIM) && (sy < Y_LIM);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      busy <= busy_nxt;
      done <= (state_nxt == DONE);
      plot <= busy_nxt && on_screen;
      if (busy_nxt) begin
        x_out      <= sx[7:0];
        y_out      <= sy[6:0];
        colour_out <= erasing ? BG_COLOUR : SPRITE_COLOUR;
      end
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: expected per-cycle outputs
// are queued when start is driven and compared at each falling edge.
module tb_sprite_plotter;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       erase_en;
  logic [7:0] old_x, new_x;
  logic [6:0] old_y, new_y;
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  typedef struct {
    logic       busy;
    logic       done;
    logic       plot;
    logic       chk;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   plot_cnt = 0;

  sprite_plotter #(
    .SPRITE_W(W),
    .SPRITE_H(H),
    .BG_COLOUR(3'b000),
    .SPRITE_COLOUR(3'b110),
    .SCREEN_W(160),
    .SCREEN_H(120)
  ) dut (
    .clock(clk),
    .reset(rst),
    .start(start),
    .erase_en(erase_en),
    .old_x(old_x),
    .old_y(old_y),
    .new_x(new_x),
    .new_y(new_y),
    .busy(busy),
    .done(done),
    .x_out(x_out),
    .y_out(y_out),
    .colour_out(colour_out),
    .plot(plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_px(input int bx, input int by, input int dx,
                         input int dy, input logic [2:0] col);
    exp_t e;
    int sx, sy;
    sx     = bx + dx;
    sy     = by + dy;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.plot = (sx < 160) && (sy < 120);
    e.chk  = 1'b1;
    e.x    = 8'(sx);
    e.y    = 7'(sy);
    e.c    = col;
    q.push_back(e);
  endtask

  task automatic push_job(input logic e, input int ox, input int oy,
                          input int nx, input int ny);
    exp_t t;
    if (e)
      for (int dy = 0; dy < H; dy++)
        for (int dx = 0; dx < W; dx++)
          push_px(ox, oy, dx, dy, 3'b000);
    for (int dy = 0; dy < H; dy++)
      for (int dx = 0; dx < W; dx++)
        push_px(nx, ny, dx, dy, 3'b110);
    t = '{busy: 1'b0, done: 1'b1, plot: 1'b0, chk: 1'b0,
          x: 8'h0, y: 7'h0, c: 3'b0};
    q.push_back(t);
    t.done = 1'b0;
    q.push_back(t);
  endtask

  task automatic go(input logic e, input int ox, input int oy,
                    input int nx, input int ny);
    erase_en = e;
    old_x    = 8'(ox);
    old_y    = 7'(oy);
    new_x    = 8'(nx);
    new_y    = 7'(ny);
    start    = 1'b1;
    push_job(e, ox, oy, nx, ny);
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      check("timeout", q.size(), 0);
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (plot) begin
        plot_cnt++;
        check("no_010", {29'b0, colour_out}, 3'b000 | ((colour_out == 3'b010) ? 3'b111 : colour_out));
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("busy", busy, e.busy);
        check("done", done, e.done);
        check("plot", plot, e.plot);
        if (e.chk) begin
          check("x", x_out, e.x);
          check("y", y_out, e.y);
          check("colour", colour_out, e.c);
        end
      end else begin
        check("idle_plot", plot, 1'b0);
        check("idle_busy", busy, 1'b0);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    erase_en = 1'b0;
    old_x    = '0;
    old_y    = '0;
    new_x    = '0;
    new_y    = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_plot", plot, 1'b0);
    check("rst_x", x_out, 8'd0);
    check("rst_y", y_out, 7'd0);
    check("rst_col", colour_out, 3'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;

    // erase+draw with stray starts at cycles 5 and 129, then 130 accepted
    plot_cnt = 0;
    go(1'b1, 10, 20, 11, 20);
    for (int k = 2; k <= 131; k++) begin
      @(negedge clk);
      #1;
      if (k == 5) begin
        start = 1'b1;
        old_x = 8'd90;
        new_x = 8'd70;
        new_y = 7'd3;
      end
      if (k == 6) start = 1'b0;
      if (k == 129) begin
        start = 1'b1;
        erase_en = 1'b1;
        new_x = 8'd99;
      end
      if (k == 130) begin
        check("first_plots", plot_cnt, 2 * N);
        erase_en = 1'b0;
        old_x = 8'd1;
        old_y = 7'd1;
        new_x = 8'd40;
        new_y = 7'd50;
        push_job(1'b0, 1, 1, 40, 50);
      end
      if (k == 131) start = 1'b0;
    end
    drain(N + 10);

    // draw only at origin
    plot_cnt = 0;
    go(1'b0, 5, 5, 0, 0);
    drain(N + 10);
    check("origin_plots", plot_cnt, N);

    // clipping at the bottom-right corner
    plot_cnt = 0;
    go(1'b0, 0, 0, 156, 116);
    drain(N + 10);
    check("clip_plots", plot_cnt, 16);

    // asynchronous reset mid-DRAW
    go(1'b1, 30, 40, 31, 41);
    repeat (N + 10) @(negedge clk);
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    check("arst_plot", plot, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_x", x_out, 8'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    plot_cnt = 0;
    go(1'b1, 30, 40, 30, 40);
    drain(2 * N + 10);
    check("post_rst_plots", plot_cnt, 2 * N);

    // random frames, colour 010 must never be plotted
    for (int f = 0; f < 1000; f++) begin
      go(1'b0, $urandom_range(0, 255), $urandom_range(0, 127),
         $urandom_range(0, 255), $urandom_range(0, 127));
      drain(N + 10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
